// File: rtl/dccm_arbiter.sv
// dccm_arbiter
//   Shares the DCCM read port and write port between the EXU LSU (port 0)
//   and a DMA/debug master (port 1). The LSU has fixed priority; a starvation
//   counter hands priority to the DMA for exactly one grant once it has been
//   denied STARVE_LIMIT consecutive cycles. A read and a write to different
//   words can both issue in the same cycle, one on each DCCM port.
//
//   Ports
//     clk, rst_n                 core clock, async active-low reset
//     lsu_req/we/addr/wdata      LSU request (held until lsu_gnt)
//     lsu_gnt                    LSU request accepted this cycle (combinational)
//     lsu_rvalid/rdata           LSU read return
//     dma_*                      same set for the DMA/debug port
//     dccm_raddr/rvalid_in       DCCM read address and strobe
//     dccm_rdata/rvalid_out      DCCM read data and valid (READ_LAT after strobe)
//     dccm_waddr/wen/wdata       DCCM write address, strobe, data
//     arb_conflicts              cycles with at least one denied request
//                                (present only with DCCM_ARB_PERF_EN defined)
//
//   Optional feature macro: DCCM_ARB_PERF_EN

module dccm_arbiter #(
    parameter int XLEN         = 32,
    parameter int READ_LAT     = 1,
    parameter int STARVE_LIMIT = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            lsu_req,
    input  logic            lsu_we,
    input  logic [XLEN-1:0] lsu_addr,
    input  logic [XLEN-1:0] lsu_wdata,
    output logic            lsu_gnt,
    output logic            lsu_rvalid,
    output logic [XLEN-1:0] lsu_rdata,
    input  logic            dma_req,
    input  logic            dma_we,
    input  logic [XLEN-1:0] dma_addr,
    input  logic [XLEN-1:0] dma_wdata,
    output logic            dma_gnt,
    output logic            dma_rvalid,
    output logic [XLEN-1:0] dma_rdata,
    output logic [XLEN-1:0] dccm_raddr,
    output logic            dccm_rvalid_in,
    input  logic [XLEN-1:0] dccm_rdata,
    input  logic            dccm_rvalid_out,
    output logic [XLEN-1:0] dccm_waddr,
    output logic            dccm_wen,
    output logic [XLEN-1:0] dccm_wdata
`ifdef DCCM_ARB_PERF_EN
    ,
    output logic [31:0]     arb_conflicts
`endif
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    logic [SW-1:0]       starve_cnt;
    logic                dma_prio;
    logic                dual_ok;
    logic                rd_lsu, rd_dma, wr_lsu, wr_dma;
    logic [READ_LAT-1:0] pipe_vld;
    logic [READ_LAT-1:0] pipe_own;
    logic                ret_hit;

    assign dma_prio = (starve_cnt == LIMIT);

    // A read and a write only conflict when they target the same word.
    assign dual_ok = (lsu_we != dma_we) && (lsu_addr[XLEN-1:2] != dma_addr[XLEN-1:2]);

    // Grants are forced low during reset so every output reads 0 while rst_n=0.
    assign lsu_gnt = rst_n && lsu_req && (!dma_req || dual_ok || !dma_prio);
    assign dma_gnt = rst_n && dma_req && (!lsu_req || dual_ok ||  dma_prio);

    assign rd_lsu = lsu_gnt && !lsu_we;
    assign rd_dma = dma_gnt && !dma_we;
    assign wr_lsu = lsu_gnt &&  lsu_we;
    assign wr_dma = dma_gnt &&  dma_we;

    always_comb begin
        dccm_rvalid_in = rd_lsu || rd_dma;
        dccm_raddr     = '0;
        if (rd_lsu)      dccm_raddr = lsu_addr;
        else if (rd_dma) dccm_raddr = dma_addr;

        dccm_wen   = wr_lsu || wr_dma;
        dccm_waddr = '0;
        dccm_wdata = '0;
        if (wr_lsu) begin
            dccm_waddr = lsu_addr;
            dccm_wdata = lsu_wdata;
        end else if (wr_dma) begin
            dccm_waddr = dma_addr;
            dccm_wdata = dma_wdata;
        end
    end

    // Counter clears whenever the DMA is idle or served; saturates at the limit
    // so the DMA keeps priority until it actually receives its grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!dma_req || dma_gnt) begin
            starve_cnt <= '0;
        end else if (starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // Fixed-latency owner pipe: entry issued in cycle t is at the head in
    // cycle t+READ_LAT, exactly when the DCCM returns its data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= '0;
            pipe_own <= '0;
        end else begin
            pipe_vld[0] <= dccm_rvalid_in;
            pipe_own[0] <= rd_dma;
            for (int i = 1; i < READ_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_own[i] <= pipe_own[i-1];
            end
        end
    end

    assign ret_hit    = dccm_rvalid_out && pipe_vld[READ_LAT-1];
    assign lsu_rvalid = ret_hit && !pipe_own[READ_LAT-1];
    assign dma_rvalid = ret_hit &&  pipe_own[READ_LAT-1];
    assign lsu_rdata  = lsu_rvalid ? dccm_rdata : '0;
    assign dma_rdata  = dma_rvalid ? dccm_rdata : '0;

`ifdef DCCM_ARB_PERF_EN
    // One count per cycle in which any request is left waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arb_conflicts <= '0;
        end else if ((lsu_req && !lsu_gnt) || (dma_req && !dma_gnt)) begin
            arb_conflicts <= arb_conflicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dccm_arbiter.sv
// tb_dccm_arbiter
//   Self-checking bench for dccm_arbiter (READ_LAT=1, STARVE_LIMIT=8).
//   A one-cycle DCCM model serves reads; a reference memory and an arbitration
//   model predict grants, DCCM strobes and read data. Expected read data is
//   queued per port at issue and popped when that port reports rvalid.

module tb_dccm_arbiter;

    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lsu_req, lsu_we, dma_req, dma_we;
    logic [31:0] lsu_addr, lsu_wdata, dma_addr, dma_wdata;
    logic        lsu_gnt, lsu_rvalid, dma_gnt, dma_rvalid;
    logic [31:0] lsu_rdata, dma_rdata;
    logic [31:0] dccm_raddr, dccm_rdata, dccm_waddr, dccm_wdata;
    logic        dccm_rvalid_in, dccm_rvalid_out, dccm_wen;
`ifdef DCCM_ARB_PERF_EN
    logic [31:0] arb_conflicts;
`endif

    int n_chk = 0;
    int n_err = 0;
    int sc = 0;
    int conf = 0;
    logic [31:0] ref_mem [0:255];
    logic [31:0] lsu_q [$];
    logic [31:0] dma_q [$];

    always #5 clk = ~clk;

    dccm_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .dccm_raddr(dccm_raddr), .dccm_rvalid_in(dccm_rvalid_in),
        .dccm_rdata(dccm_rdata), .dccm_rvalid_out(dccm_rvalid_out),
        .dccm_waddr(dccm_waddr), .dccm_wen(dccm_wen), .dccm_wdata(dccm_wdata)
`ifdef DCCM_ARB_PERF_EN
        , .arb_conflicts(arb_conflicts)
`endif
    );

    // One-cycle DCCM model (not reset: a return in flight still arrives).
    logic [31:0] mem [0:255];
    logic        rd_v_q = 1'b0;
    logic [31:0] rd_d_q = 32'h0;
    always @(posedge clk) begin
        if (dccm_wen) mem[dccm_waddr[9:2]] <= dccm_wdata;
        rd_v_q <= dccm_rvalid_in;
        rd_d_q <= mem[dccm_raddr[9:2]];
    end
    assign dccm_rvalid_out = rd_v_q;
    assign dccm_rdata      = rd_d_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drives one cycle of requests (called just after a posedge), checks all
    // outputs at the negedge and advances the reference model.
    task automatic cyc(input logic lr, input logic lw, input logic [31:0] la, input logic [31:0] ld,
                       input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd,
                       output logic egl, output logic egd);
        logic prio, dual, erl, erd, ewl, ewd;
        logic [31:0] exp_raddr, exp_waddr, exp_wdata, e;
        lsu_req = lr; lsu_we = lw; lsu_addr = la; lsu_wdata = ld;
        dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
        prio = (sc == LIMIT);
        dual = (lw != dw) && (la[31:2] != da[31:2]);
        egl  = lr && (!dr || dual || !prio);
        egd  = dr && (!lr || dual || prio);
        erl = egl && !lw;  erd = egd && !dw;
        ewl = egl && lw;   ewd = egd && dw;
        exp_raddr = erl ? la : (erd ? da : 32'h0);
        exp_waddr = ewl ? la : (ewd ? da : 32'h0);
        exp_wdata = ewl ? ld : (ewd ? dd : 32'h0);
        @(negedge clk);
        check("lsu_gnt", 32'(lsu_gnt), 32'(egl));
        check("dma_gnt", 32'(dma_gnt), 32'(egd));
        check("dccm_rvalid_in", 32'(dccm_rvalid_in), 32'(erl || erd));
        check("dccm_raddr", dccm_raddr, exp_raddr);
        check("dccm_wen", 32'(dccm_wen), 32'(ewl || ewd));
        check("dccm_waddr", dccm_waddr, exp_waddr);
        check("dccm_wdata", dccm_wdata, exp_wdata);
        check("lsu_rvalid", 32'(lsu_rvalid), 32'(lsu_q.size() != 0));
        check("dma_rvalid", 32'(dma_rvalid), 32'(dma_q.size() != 0));
        if (lsu_q.size() != 0) begin
            e = lsu_q.pop_front();
            if (lsu_rvalid) check("lsu_rdata", lsu_rdata, e);
        end
        if (dma_q.size() != 0) begin
            e = dma_q.pop_front();
            if (dma_rvalid) check("dma_rdata", dma_rdata, e);
        end
        if (erl) lsu_q.push_back(ref_mem[la[9:2]]);
        if (erd) dma_q.push_back(ref_mem[da[9:2]]);
        if (ewl) ref_mem[la[9:2]] = ld;
        if (ewd) ref_mem[da[9:2]] = dd;
        if ((lr && !egl) || (dr && !egd)) conf++;
        if (!dr || egd) sc = 0;
        else if (sc < LIMIT) sc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        logic gl, gd;
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, gl, gd);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_lsu_gnt"}, 32'(lsu_gnt), 32'h0);
        check({tag, "_dma_gnt"}, 32'(dma_gnt), 32'h0);
        check({tag, "_lsu_rvalid"}, 32'(lsu_rvalid), 32'h0);
        check({tag, "_dma_rvalid"}, 32'(dma_rvalid), 32'h0);
        check({tag, "_lsu_rdata"}, lsu_rdata, 32'h0);
        check({tag, "_dma_rdata"}, dma_rdata, 32'h0);
        check({tag, "_rvalid_in"}, 32'(dccm_rvalid_in), 32'h0);
        check({tag, "_raddr"}, dccm_raddr, 32'h0);
        check({tag, "_wen"}, 32'(dccm_wen), 32'h0);
        check({tag, "_waddr"}, dccm_waddr, 32'h0);
        check({tag, "_wdata"}, dccm_wdata, 32'h0);
`ifdef DCCM_ARB_PERF_EN
        check({tag, "_conflicts"}, arb_conflicts, 32'h0);
`endif
    endtask

    function automatic logic [31:0] rnd_addr();
        return 32'h100 + 32'($urandom_range(0, 7)) * 32'd4 + 32'($urandom_range(0, 3));
    endfunction

    initial begin
        logic gl, gd;
        logic plr, plw, pdr, pdw;
        logic [31:0] pla, pld, pda, pdd, la, da;
        int first_dma, n_dma;
`ifdef DCCM_ARB_PERF_EN
        logic [31:0] base;
`endif
        lsu_req = 0; lsu_we = 0; lsu_addr = 0; lsu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;

        // Reset state, with requests asserted to show gnt is held low.
        lsu_req = 1; dma_req = 1; dma_we = 1;
        @(negedge clk);
        check_all_zero("reset");
        lsu_req = 0; dma_req = 0; dma_we = 0;
        @(posedge clk); #1;
        rst_n = 1;

        // Preload every word through the arbiter, alternating ports.
        for (int i = 0; i < 256; i++) begin
            logic [31:0] w;
            w = (i == 64) ? 32'hDEADBEEF : (32'hC0DE0000 ^ (32'(i) * 32'h01010101));
            if (i % 2 == 0) cyc(1'b1, 1'b1, 32'(i) * 4, w, 1'b0, 1'b0, 32'h0, 32'h0, gl, gd);
            else            cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'(i) * 4, w, gl, gd);
        end

        // Single LSU read with DMA idle.
        cyc(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, gl, gd);
        idle();
        // LSU write + DMA read, different words: both issue.
        cyc(1'b1, 1'b1, 32'h200, 32'h11112222, 1'b1, 1'b0, 32'h300, 32'h0, gl, gd);
        idle();
        cyc(1'b1, 1'b1, 32'h200, 32'h33334444, 1'b1, 1'b0, 32'h204, 32'h0, gl, gd);
        // Same word: only LSU, DMA follows next cycle and sees the new data.
        cyc(1'b1, 1'b1, 32'h200, 32'h55556666, 1'b1, 1'b0, 32'h202, 32'h0, gl, gd);
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h202, 32'h0, gl, gd);
        // DMA write + LSU read on different words; then two writes collide.
        cyc(1'b1, 1'b0, 32'h104, 32'h0, 1'b1, 1'b1, 32'h108, 32'h77778888, gl, gd);
        cyc(1'b1, 1'b1, 32'h10C, 32'hAAAA0001, 1'b1, 1'b1, 32'h110, 32'hBBBB0002, gl, gd);
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h110, 32'hBBBB0002, gl, gd);
        idle();

        // Both ports reading continuously: DMA served every ninth cycle.
`ifdef DCCM_ARB_PERF_EN
        base = arb_conflicts;
`endif
        la = 32'h100; da = 32'h180; first_dma = 0; n_dma = 0;
        for (int k = 1; k <= 18; k++) begin
            cyc(1'b1, 1'b0, la, 32'h0, 1'b1, 1'b0, da, 32'h0, gl, gd);
            if (gl) la = la + 32'd4;
            if (gd) begin
                n_dma++;
                if (first_dma == 0) first_dma = k;
                da = da + 32'd4;
            end
        end
        idle();
        check("starve_first_dma_cycle", 32'(first_dma), 32'd9);
        check("starve_dma_grants", 32'(n_dma), 32'd2);
`ifdef DCCM_ARB_PERF_EN
        check("perf_starve_delta", arb_conflicts - base, 32'd19 - 32'd1);
`endif

        // Reset with an LSU read in flight: the return must be dropped.
        cyc(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, gl, gd);
        rst_n = 0;
        @(negedge clk);
        check_all_zero("midrst");
        lsu_q.delete(); dma_q.delete(); sc = 0; conf = 0;
        lsu_req = 0;
        @(posedge clk); #1;
        rst_n = 1;
        idle();
        idle();

        // Random traffic honouring the hold-until-grant handshake.
        plr = 0; pdr = 0; plw = 0; pdw = 0; pla = 0; pld = 0; pda = 0; pdd = 0;
        for (int n = 0; n < 400; n++) begin
            if (!plr) begin
                plr = ($urandom_range(0, 3) != 0);
                plw = 1'($urandom_range(0, 1));
                pla = rnd_addr();
                pld = $urandom();
            end
            if (!pdr) begin
                pdr = ($urandom_range(0, 3) != 0);
                pdw = 1'($urandom_range(0, 1));
                pda = rnd_addr();
                pdd = $urandom();
            end
            cyc(plr, plw, pla, pld, pdr, pdw, pda, pdd, gl, gd);
            if (gl) plr = 0;
            if (gd) pdr = 0;
        end
        idle();
        idle();
`ifdef DCCM_ARB_PERF_EN
        check("perf_total", arb_conflicts, 32'(conf));
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
